// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame scheduler and its neighbours.
//   state_t            : scheduler FSM encoding (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE)
//   DEFAULT_HEADER_TAG : default upper nibble of the frame header byte
//   BIT_PERIOD         : UART bit period in CLK cycles (100 MHz / 9600 baud)
//   header_byte()      : builds {tag, 3'b000, source id}
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [3:0]  DEFAULT_HEADER_TAG = 4'hA;
  localparam int unsigned BIT_PERIOD         = 10416;

  function automatic logic [7:0] header_byte(input logic [3:0] tag, input logic id);
    return {tag, 3'b000, id};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req      : request bits, req[i] from requester i
//   accept   : strobe, the current grant is taken; updates the pointer
//   grant    : one-hot grant (combinational), '0 when nothing requests
// The pointer remembers the last winner and resets to 1, so requester 0
// wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one byte-wide UART transmitter between two requesters. Each grant
// produces a frame of a header byte {HEADER_TAG, 3'b000, GRANT_ID} followed
// by NBYTES payload bytes, most significant first.
//   CLK, RST               : clock, synchronous active-high reset
//   REQ0_VALID/DATA/ACK    : requester 0 handshake (ACK = one-cycle capture pulse)
//   REQ1_VALID/DATA/ACK    : requester 1 handshake
//   TX_SEND, TX_DATA       : one-cycle byte strobe and byte to the UART
//   TX_READY               : UART idle
//   ACTIVE                 : a frame is in progress
//   GRANT_ID               : source of the current or most recent frame
module uart_frame_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NBYTES     = 4,
  parameter logic [3:0]  HEADER_TAG = DEFAULT_HEADER_TAG
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ0_VALID,
  input  logic [8*NBYTES-1:0] REQ0_DATA,
  output logic                REQ0_ACK,
  input  logic                REQ1_VALID,
  input  logic [8*NBYTES-1:0] REQ1_DATA,
  output logic                REQ1_ACK,
  output logic                TX_SEND,
  output logic [7:0]          TX_DATA,
  input  logic                TX_READY,
  output logic                ACTIVE,
  output logic                GRANT_ID
);

  localparam int unsigned PW        = 8 * NBYTES;
  localparam logic [3:0]  FRAME_LEN = 4'(NBYTES + 1);

  state_t          state;
  logic [3:0]      cnt;
  logic [PW-1:0]   shreg;
  logic [1:0]      req;
  logic [1:0]      grant;
  logic            accept;
  logic [7:0]      next_byte;

  assign req    = {REQ1_VALID, REQ0_VALID};
  assign accept = (state == IDLE) && (grant != 2'b00);

  rr_arbiter2 u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  // The counter still holding FRAME_LEN means the header has not gone out yet.
  always_comb begin
    next_byte = shreg[PW-1 -: 8];
    if (cnt == FRAME_LEN) begin
      next_byte = header_byte(HEADER_TAG, GRANT_ID);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      TX_SEND  <= 1'b0;
      TX_DATA  <= '0;
      REQ0_ACK <= 1'b0;
      REQ1_ACK <= 1'b0;
      ACTIVE   <= 1'b0;
      GRANT_ID <= 1'b0;
    end else begin
      TX_SEND  <= 1'b0;
      REQ0_ACK <= 1'b0;
      REQ1_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= grant[1] ? REQ1_DATA : REQ0_DATA;
            cnt      <= FRAME_LEN;
            REQ0_ACK <= grant[0];
            REQ1_ACK <= grant[1];
            GRANT_ID <= grant[1];
            ACTIVE   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (TX_READY) begin
            TX_SEND <= 1'b1;
            TX_DATA <= next_byte;
            state   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!TX_READY) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (TX_READY) begin
            cnt <= cnt - 4'd1;
            // Only shift once a payload byte has left; the header does not
            // consume any of the shift register.
            if (cnt != FRAME_LEN) begin
              shreg <= shreg << 8;
            end
            if (cnt == 4'd1) begin
              ACTIVE <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench for uart_frame_scheduler: dut_a (NBYTES=4) and
// dut_b (NBYTES=1), each driving a small behavioural UART model.
module tb_uart_frame_scheduler;
  import uart_pkg::*;

  localparam int UART_CYC = BIT_PERIOD / 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // ---------------- DUT A (NBYTES=4) ----------------
  logic        rst_a = 1'b1;
  logic        a_req0_valid = 1'b0, a_req1_valid = 1'b0;
  logic [31:0] a_req0_data = '0, a_req1_data = '0;
  logic        a_ack0, a_ack1, a_tx_send, a_active, a_grant_id;
  logic [7:0]  a_tx_data;
  logic        a_tx_ready;
  logic        a_hold_low = 1'b0;
  int          a_busy = 0;

  uart_frame_scheduler #(.NBYTES(4), .HEADER_TAG(4'hA)) dut_a (
    .CLK        (clk),
    .RST        (rst_a),
    .REQ0_VALID (a_req0_valid),
    .REQ0_DATA  (a_req0_data),
    .REQ0_ACK   (a_ack0),
    .REQ1_VALID (a_req1_valid),
    .REQ1_DATA  (a_req1_data),
    .REQ1_ACK   (a_ack1),
    .TX_SEND    (a_tx_send),
    .TX_DATA    (a_tx_data),
    .TX_READY   (a_tx_ready),
    .ACTIVE     (a_active),
    .GRANT_ID   (a_grant_id)
  );

  // UART model: no reset, busy for UART_CYC cycles after each accepted strobe.
  assign a_tx_ready = (a_busy == 0) && !a_hold_low;
  always @(posedge clk) begin
    if (a_tx_send && a_tx_ready) a_busy <= UART_CYC;
    else if (a_busy != 0)        a_busy <= a_busy - 1;
  end

  // ---------------- DUT B (NBYTES=1) ----------------
  logic       rst_b = 1'b1;
  logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic [7:0] b_req0_data = '0, b_req1_data = '0;
  logic       b_ack0, b_ack1, b_tx_send, b_active, b_grant_id;
  logic [7:0] b_tx_data;
  logic       b_tx_ready;
  int         b_busy = 0;

  uart_frame_scheduler #(.NBYTES(1), .HEADER_TAG(4'hA)) dut_b (
    .CLK        (clk),
    .RST        (rst_b),
    .REQ0_VALID (b_req0_valid),
    .REQ0_DATA  (b_req0_data),
    .REQ0_ACK   (b_ack0),
    .REQ1_VALID (b_req1_valid),
    .REQ1_DATA  (b_req1_data),
    .REQ1_ACK   (b_ack1),
    .TX_SEND    (b_tx_send),
    .TX_DATA    (b_tx_data),
    .TX_READY   (b_tx_ready),
    .ACTIVE     (b_active),
    .GRANT_ID   (b_grant_id)
  );

  assign b_tx_ready = (b_busy == 0);
  always @(posedge clk) begin
    if (b_tx_send && b_tx_ready) b_busy <= UART_CYC;
    else if (b_busy != 0)        b_busy <= b_busy - 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_a[$];
  logic       exp_ack_a[$];
  logic [7:0] exp_b[$];
  logic       exp_ack_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  int   a_sends = 0, b_sends = 0, a_fall = 0;
  logic a_prev_send = 1'b0, a_prev_active = 1'b0, b_prev_send = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (a_tx_send) begin
      check("a_send_while_busy", a_tx_ready, 1);
      check("a_send_back_to_back", a_prev_send, 0);
      if (exp_a.size() == 0) flag("a_unexpected_send");
      else check("a_tx_data", a_tx_data, exp_a.pop_front());
      a_sends++;
    end
    if (a_ack0 && a_ack1) flag("a_double_ack");
    if (a_ack0 || a_ack1) begin
      if (exp_ack_a.size() == 0) flag("a_unexpected_ack");
      else check("a_ack_id", a_ack1, exp_ack_a.pop_front());
      check("a_grant_id", a_grant_id, a_ack1);
      check("a_active_on_ack", a_active, 1);
    end
    if (a_prev_active && !a_active) a_fall = cyc;
    a_prev_send   = a_tx_send;
    a_prev_active = a_active;
  end

  always @(negedge clk) begin
    if (b_tx_send) begin
      check("b_send_while_busy", b_tx_ready, 1);
      check("b_send_back_to_back", b_prev_send, 0);
      if (exp_b.size() == 0) flag("b_unexpected_send");
      else check("b_tx_data", b_tx_data, exp_b.pop_front());
      b_sends++;
    end
    if (b_ack0 && b_ack1) flag("b_double_ack");
    if (b_ack0 || b_ack1) begin
      if (exp_ack_b.size() == 0) flag("b_unexpected_ack");
      else check("b_ack_id", b_ack1, exp_ack_b.pop_front());
    end
    b_prev_send = b_tx_send;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] hdr, input logic [31:0] d);
    exp_a.push_back(hdr);
    exp_a.push_back(d[31:24]);
    exp_a.push_back(d[23:16]);
    exp_a.push_back(d[15:8]);
    exp_a.push_back(d[7:0]);
  endtask

  task automatic wait_ack_a(input string name);
    int n = 0;
    do begin tick(); n++; end while (!(a_ack0 || a_ack1) && n < 400);
    if (!(a_ack0 || a_ack1)) flag(name);
  endtask

  task automatic wait_sends_a(input int target, input string name);
    int n = 0;
    while (a_sends < target && n < 2000) begin tick(); n++; end
    if (a_sends < target) flag(name);
  endtask

  // Drain the queue, then watch TX_READY fall and rise; ACTIVE must be low
  // one cycle after the final rise.
  task automatic wait_frame_end_a(input string name);
    int n = 0;
    while (exp_a.size() != 0 && n < 3000) begin tick(); n++; end
    n = 0;
    while (a_tx_ready && n < 50) begin tick(); n++; end
    n = 0;
    while (!a_tx_ready && n < 200) begin tick(); n++; end
    if (!a_tx_ready || exp_a.size() != 0) flag(name);
    tick();
    check(name, a_active, 0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_tx_send"},  a_tx_send, 0);
    check({tag, "_tx_data"},  a_tx_data, 8'h00);
    check({tag, "_ack0"},     a_ack0, 0);
    check({tag, "_ack1"},     a_ack1, 0);
    check({tag, "_active"},   a_active, 0);
    check({tag, "_grant_id"}, a_grant_id, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int n;
    repeat (3) tick();
    check_reset_a("rst_a");
    check("rst_b_tx_data", b_tx_data, 8'h00);
    check("rst_b_active", b_active, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // 1: single request, DEADBEEF
    push_a(8'hA0, 32'hDEADBEEF);
    exp_ack_a.push_back(1'b0);
    a_req0_data  = 32'hDEADBEEF;
    a_req0_valid = 1'b1;
    wait_ack_a("t1_ack");
    a_req0_valid = 1'b0;
    wait_frame_end_a("t1_active_fall");

    // 2: simultaneous after reset, alternating winners while both held
    rst_a = 1'b1; tick(); rst_a = 1'b0; tick();
    push_a(8'hA0, 32'h11223344);
    push_a(8'hA1, 32'h55667788);
    push_a(8'hA0, 32'h11223344);
    push_a(8'hA1, 32'h55667788);
    exp_ack_a.push_back(1'b0);
    exp_ack_a.push_back(1'b1);
    exp_ack_a.push_back(1'b0);
    exp_ack_a.push_back(1'b1);
    a_req0_data  = 32'h11223344;
    a_req1_data  = 32'h55667788;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) wait_ack_a("t2_ack");
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    wait_frame_end_a("t2_active_fall");

    // 3: REQ1 raised during the 2nd byte of a REQ0 frame
    base = a_sends;
    push_a(8'hA0, 32'hCAFEBABE);
    push_a(8'hA1, 32'h0BADF00D);
    exp_ack_a.push_back(1'b0);
    exp_ack_a.push_back(1'b1);
    a_req0_data  = 32'hCAFEBABE;
    a_req1_data  = 32'h0BADF00D;
    a_req0_valid = 1'b1;
    wait_ack_a("t3_ack0");
    a_req0_valid = 1'b0;
    wait_sends_a(base + 2, "t3_two_bytes");
    a_req1_valid = 1'b1;
    wait_ack_a("t3_ack1");
    a_req1_valid = 1'b0;
    check("t3_sends_before_ack1", a_sends - base, 5);
    check("t3_grant_latency_ok", (cyc - a_fall) <= 2, 1);
    wait_frame_end_a("t3_active_fall");

    // 4: TX_READY held low for 200 cycles before the header
    a_hold_low = 1'b1;
    push_a(8'hA0, 32'h13579BDF);
    exp_ack_a.push_back(1'b0);
    a_req0_data  = 32'h13579BDF;
    a_req0_valid = 1'b1;
    wait_ack_a("t4_ack");
    a_req0_valid = 1'b0;
    base = a_sends;
    repeat (200) tick();
    check("t4_no_send_while_low", a_sends - base, 0);
    a_hold_low = 1'b0;
    tick();
    check("t4_send_after_rise", a_tx_send, 1);
    check("t4_header", a_tx_data, 8'hA0);
    wait_frame_end_a("t4_active_fall");

    // 5: reset during the 3rd byte while the UART is busy
    base = a_sends;
    exp_a.push_back(8'hA1);
    exp_a.push_back(8'h01);
    exp_a.push_back(8'h02);
    exp_ack_a.push_back(1'b1);
    a_req1_data  = 32'h01020304;
    a_req1_valid = 1'b1;
    wait_ack_a("t5_ack");
    a_req1_valid = 1'b0;
    wait_sends_a(base + 3, "t5_three_bytes");
    tick();
    check("t5_uart_busy", a_tx_ready, 0);
    rst_a = 1'b1;
    tick();
    check_reset_a("t5_rst");
    rst_a = 1'b0;
    // pointer is back at 1, so REQ0 wins the tie
    push_a(8'hA0, 32'h0A0B0C0D);
    push_a(8'hA1, 32'hA1B2C3D4);
    exp_ack_a.push_back(1'b0);
    exp_ack_a.push_back(1'b1);
    a_req0_data  = 32'h0A0B0C0D;
    a_req1_data  = 32'hA1B2C3D4;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    wait_ack_a("t5_ack_after_rst0");
    a_req0_valid = 1'b0;
    wait_ack_a("t5_ack_after_rst1");
    a_req1_valid = 1'b0;
    wait_frame_end_a("t5_active_fall");

    // 6: NBYTES=1 instance
    exp_b.push_back(8'hA1);
    exp_b.push_back(8'h5A);
    exp_ack_b.push_back(1'b1);
    b_req1_data  = 8'h5A;
    b_req1_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!b_ack1 && n < 100);
    if (!b_ack1) flag("t6_ack");
    b_req1_valid = 1'b0;
    n = 0;
    while ((b_active || exp_b.size() != 0) && n < 500) begin tick(); n++; end
    if (b_active) flag("t6_active_fall");
    repeat (30) tick();
    check("t6_send_count", b_sends, 2);

    check("a_bytes_left", exp_a.size(), 0);
    check("a_acks_left", exp_ack_a.size(), 0);
    check("b_bytes_left", exp_b.size(), 0);
    check("b_acks_left", exp_ack_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Shares the single byte-wide UART transmitter between two producers (game-state reporter and debug counter) and turns each producer request into a framed multi-byte message. Arbitrates round-robin, latches the winning payload, prepends a header byte carrying the source ID, then feeds bytes one at a time through the transmitter's SEND/DATA/READY handshake. It sits between the producers and the UART transmitter.

## Interface
Parameters:
- NBYTES, 4: payload bytes per frame, legal range 1..8.
- HEADER_TAG, 4'hA: upper nibble of the header byte.

Ports:
- CLK  in  1  system clock (100 MHz).
- RST  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has a message.
- REQ0_DATA  in  8*NBYTES  requester 0 payload; must stay stable while REQ0_VALID=1 and REQ0_ACK=0.
- REQ0_ACK  out  1  one-cycle pulse: the payload was captured.
- REQ1_VALID, REQ1_DATA, REQ1_ACK: same as the REQ0 ports, for requester 1.
- TX_SEND  out  1  one-cycle send strobe to the UART.
- TX_DATA  out  8  byte to transmit; valid when TX_SEND=1.
- TX_READY  in  1  UART idle.
- ACTIVE  out  1  a frame is in progress (any state other than IDLE).
- GRANT_ID  out  1  source of the current or most recent frame.

## Operation
- The block is one clock domain and is synchronous to CLK.
- Each frame is NBYTES+1 bytes, in this order:
  - Header byte: {HEADER_TAG, 3'b000, GRANT_ID}.
  - Then the payload, most significant byte first: DATA[8*NBYTES-1:8*NBYTES-8] down to DATA[7:0].
- Arbitration (IDLE only):
  - Only one requester valid: it wins.
  - Both valid: the requester that did not win last time wins.
  - The last-winner pointer resets to 1, so REQ0 wins the first tie.
- On a grant:
  - The payload is latched into an internal shift register.
  - The byte counter is loaded with NBYTES+1.
  - ACK is pulsed to the winner.
  - The requester may drop VALID or change DATA from the cycle after ACK.
- States:
  - IDLE: wait for any VALID. On a grant go to ISSUE.
  - ISSUE: wait for TX_READY=1. When it is seen, assert TX_SEND with TX_DATA for one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for TX_READY=0 (the UART accepted the byte), then go to WAIT_DONE.
  - WAIT_DONE: wait for TX_READY=1. Then decrement the counter and shift the payload left by 8. If the counter reaches 0, go to IDLE; otherwise go to ISSUE.
- A requester holding VALID through a frame is not re-granted until the frame ends. It then competes under the round-robin rule.
- Reset mid-frame:
  - State returns to IDLE and the frame is abandoned; no ACK is re-issued.
  - The UART itself has no reset and may still be shifting the last byte. The ISSUE wait on TX_READY guarantees no strobe is issued while it is busy.
- Reset values:
  - TX_SEND=0, TX_DATA=8'h00, REQ0_ACK=0, REQ1_ACK=0, ACTIVE=0, GRANT_ID=0.
  - Last-winner pointer = 1, counter = 0.

## Timing
- All outputs are registered.
- VALID sampled high in IDLE at edge t: ACK is high during cycle t+1 and ACTIVE rises at t+1.
- TX_SEND for the header is high no earlier than cycle t+2, provided TX_READY=1.
- TX_SEND is never high in two consecutive cycles.
- TX_SEND is never asserted while TX_READY=0.
- At most one ACK is high in any cycle.
- Between consecutive bytes of a frame the block adds 2 cycles after TX_READY rises:
  - 1 cycle to leave WAIT_DONE;
  - 1 cycle for ISSUE to register TX_SEND.
- After the last byte completes, ACTIVE falls the cycle after TX_READY rises. A pending request is granted in the following cycle.
- Counter width: 4 bits, which covers up to 9 bytes.

## Structure
- Shared package (uart_pkg) holds:
  - state encoding: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3;
  - default HEADER_TAG;
  - bit-period constant 10416, shared with the transmitter and the bench.
- One natural sub-module: rr_arbiter2 (two request bits in, one-hot grant out, with a pointer that updates on an accept strobe).
- The datapath (shift register, counter, header mux) and the FSM stay in the top module.

## Test plan
- Single request, REQ0_DATA=32'hDEADBEEF, UART model idle.
  - REQ0_ACK pulses once.
  - TX_DATA sequence is A0, DE, AD, BE, EF.
  - ACTIVE then drops.
- Simultaneous REQ0 (32'h11223344) and REQ1 (32'h55667788) right after reset.
  - REQ0 is served first with header A0; REQ1 is served next with header A1.
  - Holding both valid gives alternating winners 0, 1, 0, 1.
- REQ1 asserted mid-way through a REQ0 frame.
  - No ACK and no extra TX_SEND until the 5th byte of REQ0 completes.
  - REQ1 is granted within 2 cycles of ACTIVE falling.
- TX_READY held low for 200 cycles before the header.
  - TX_SEND stays 0 throughout.
  - TX_SEND pulses exactly once, the cycle after TX_READY rises.
- RST pulsed during the 3rd byte while the UART model is busy.
  - Outputs return to their reset values.
  - A new request issues its header only after TX_READY returns high.
  - TX_SEND is never asserted while TX_READY=0.
- NBYTES=1, REQ1_DATA=8'h5A.
  - TX_DATA sequence is A1, 5A.
  - Exactly 2 TX_SEND pulses.
